ysyx_220053_ifetch_responder: RTL and testbench

Memory-side responder for the fetch-stage `i_rw_*` line interface. It accepts a 16-byte line read from the fetch unit and performs two 64-bit beats on a simple req/ack memory port. It returns the assembled 128-bit line with a one-cycle `i_rw_ready_o` pulse. It sits between the fetch unit and the memory/DPI model, replacing direct `pmem_read` calls on the fetch path.

---
 rtl/ysyx_220053_ifetch_responder_pkg.sv | 33 +++
 rtl/ysyx_220053_ifetch_responder.sv | 161 ++++++++++++++++
 tb/tb_ysyx_220053_ifetch_responder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_ifetch_responder_pkg.sv
`default_nettype none
// ============================================================================
// ysyx_220053_ifetch_responder_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the fetch-path line responder and the fetch unit:
// FSM state encoding, line/beat widths, request-type constants and a helper
// that aligns a byte address down to its 16-byte line base.
// Ports: none (package).
// Revision: 1.0 - initial release
// ============================================================================
package ysyx_220053_ifetch_responder_pkg;

  localparam int LINE_W = 128;
  localparam int BEAT_W = 64;

  // Request type as seen on i_rw_req_i; the fetch unit uses the same values.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Clear the low four address bits so both beats stay within one line.
  function automatic logic [63:0] line_base(input logic [63:0] addr);
    return addr & ~64'hF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_220053_ifetch_responder.sv
`default_nettype none
// ============================================================================
// ysyx_220053_ifetch_responder
// ----------------------------------------------------------------------------
// Memory-side responder for the fetch-stage i_rw_* line interface. A 16-byte
// line read is split into two 64-bit beats on a req/ack memory port and the
// assembled line is returned with a one-cycle ready strobe. Write requests
// and beats that wait too long for an ack are answered with an error.
//
// Ports:
//   clk           - clock, all logic on the rising edge
//   rst           - synchronous active-low reset
//   i_rw_valid_i  - request valid from fetch (sampled only in IDLE)
//   i_rw_req_i    - 0 = read, 1 = write (write answered with error)
//   i_rw_addr_i   - byte address, bits [3:0] ignored
//   i_rw_ready_o  - one-cycle response strobe
//   i_data_read_o - 128-bit line, valid while i_rw_ready_o = 1
//   i_rw_err_o    - error flag, valid while i_rw_ready_o = 1
//   mem_req_o     - beat request, held until ack
//   mem_addr_o    - 8-byte-aligned beat address
//   mem_ack_i     - beat complete, mem_rdata_i valid in the same cycle
//   mem_rdata_i   - 64-bit beat data
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_220053_ifetch_responder
  import ysyx_220053_ifetch_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rw_valid_i,
  input  logic              i_rw_req_i,
  input  logic [63:0]       i_rw_addr_i,
  output logic              i_rw_ready_o,
  output logic [LINE_W-1:0] i_data_read_o,
  output logic              i_rw_err_o,
  output logic              mem_req_o,
  output logic [63:0]       mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [BEAT_W-1:0] mem_rdata_i
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  state_t              state_q, state_d;
  logic [63:0]         base_q,  base_d;
  logic [LINE_W-1:0]   line_q,  line_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                err_q,   err_d;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_rw_valid_i) begin
          line_d = '0;
          cnt_d  = '0;
          if (i_rw_req_i == RW_WRITE) begin
            // Writes are not supported on the fetch path: answer at once.
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            base_d  = line_base(i_rw_addr_i);
            err_d   = 1'b0;
            state_d = ST_BEAT0;
          end
        end
      end

      ST_BEAT0: begin
        if (mem_ack_i) begin
          line_d[BEAT_W-1:0] = mem_rdata_i;
          cnt_d              = '0;
          state_d            = ST_BEAT1;
        end else if (cnt_q == C_TIMEOUT) begin
          // Abort: the partial line is discarded so fetch never sees it.
          line_d  = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end

      ST_BEAT1: begin
        if (mem_ack_i) begin
          line_d[LINE_W-1:BEAT_W] = mem_rdata_i;
          cnt_d                   = '0;
          state_d                 = ST_RESP;
        end else if (cnt_q == C_TIMEOUT) begin
          line_d  = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so the memory address is
  // stable for the whole time a beat request is held.
  // --------------------------------------------------------------------------
  assign i_rw_ready_o  = (state_q == ST_RESP);
  assign i_rw_err_o    = (state_q == ST_RESP) & err_q;
  assign i_data_read_o = line_q;
  assign mem_req_o     = (state_q == ST_BEAT0) | (state_q == ST_BEAT1);

  always_comb begin
    mem_addr_o = '0;
    if (state_q == ST_BEAT0) begin
      mem_addr_o = base_q;
    end else if (state_q == ST_BEAT1) begin
      // Upper beat of the line; 64-bit wrap is intentionally not flagged.
      mem_addr_o = base_q + 64'd8;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_220053_ifetch_responder.sv
`default_nettype none
// ============================================================================
// tb_ysyx_220053_ifetch_responder
// ----------------------------------------------------------------------------
// Self-checking bench: a table of directed read/write vectors with
// hand-computed latencies, plus hand-written sequences for reset state,
// reset mid-beat and valid held high across the response.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_220053_ifetch_responder;

  localparam int T_OUT = 6;
  localparam int NEVER = 1000;
  localparam int NVEC  = 8;

  logic         clk;
  logic         rst;
  logic         i_rw_valid_i;
  logic         i_rw_req_i;
  logic [63:0]  i_rw_addr_i;
  logic         i_rw_ready_o;
  logic [127:0] i_data_read_o;
  logic         i_rw_err_o;
  logic         mem_req_o;
  logic [63:0]  mem_addr_o;
  logic         mem_ack_i;
  logic [63:0]  mem_rdata_i;

  ysyx_220053_ifetch_responder #(
    .TIMEOUT(T_OUT),
    .CNT_W  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rw_valid_i (i_rw_valid_i),
    .i_rw_req_i   (i_rw_req_i),
    .i_rw_addr_i  (i_rw_addr_i),
    .i_rw_ready_o (i_rw_ready_o),
    .i_data_read_o(i_data_read_o),
    .i_rw_err_o   (i_rw_err_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Beat contents as a function of the beat address.
  function automatic logic [63:0] beat_data(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
  endfunction

  function automatic logic [127:0] line_of(input logic [63:0] base);
    return {beat_data(base + 64'd8), beat_data(base)};
  endfunction

  // --------------------------------------------------------------------------
  // Memory model: beat with addr[3]=0 waits dly0 cycles, addr[3]=1 waits dly1.
  // --------------------------------------------------------------------------
  int          dly0 = 0;
  int          dly1 = 0;
  int          wcnt = 0;
  logic [63:0] log0, log1;
  int          ready_cnt = 0;
  int          req_cycles = 0;

  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    log0        = '1;
    log1        = '1;
    forever begin
      @(negedge clk);
      if (!mem_req_o) begin
        mem_ack_i = 1'b0;
        wcnt      = 0;
      end else begin
        if (mem_ack_i) wcnt = 0;  // previous beat consumed, new beat starts
        if (wcnt == (mem_addr_o[3] ? dly1 : dly0)) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = beat_data(mem_addr_o);
          if (mem_addr_o[3]) log1 = mem_addr_o;
          else               log0 = mem_addr_o;
        end else begin
          mem_ack_i = 1'b0;
          wcnt++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (i_rw_ready_o) ready_cnt++;
      if (mem_req_o)    req_cycles++;
    end
  end

  // --------------------------------------------------------------------------
  // One transaction: drive a request for one cycle, measure latency, check
  // response, single pulse, beat addresses and (for writes) no memory access.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [63:0] addr;
    logic        req;
    int          d0;
    int          d1;
    int          lat;
    logic        err;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v);
    int            lat;
    int            rc0;
    int            rd0;
    logic [63:0]   base;
    logic [127:0]  exp_data;
    base     = v.addr & ~64'hF;
    exp_data = v.err ? 128'h0 : line_of(base);
    dly0 = v.d0;
    dly1 = v.d1;
    log0 = '1;
    log1 = '1;
    rc0  = req_cycles;
    rd0  = ready_cnt;
    i_rw_valid_i = 1'b1;
    i_rw_req_i   = v.req;
    i_rw_addr_i  = v.addr;
    @(posedge clk); #1;
    i_rw_valid_i = 1'b0;
    i_rw_addr_i  = 64'hDEAD_BEEF_0000_0000;
    lat = 1;
    while (!i_rw_ready_o && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(v.lat));
    chk({tag, "_err"},     128'(i_rw_err_o), 128'(v.err));
    chk({tag, "_data"},    i_data_read_o, exp_data);
    @(posedge clk); #1;
    chk({tag, "_ready_drop"}, 128'(i_rw_ready_o), 128'h0);
    chk({tag, "_pulses"}, 128'(ready_cnt - rd0), 128'd1);
    if (v.req) begin
      chk({tag, "_no_mem_req"}, 128'(req_cycles - rc0), 128'd0);
    end else if (!v.err) begin
      chk({tag, "_beat0_addr"}, 128'(log0), 128'(base));
      chk({tag, "_beat1_addr"}, 128'(log1), 128'(base + 64'd8));
    end
  endtask

  vec_t vecs[NVEC];

  initial begin
    vecs[0] = '{64'h0000_0000_8000_0010, 1'b0, 0,     0,     3,         1'b0};
    vecs[1] = '{64'h0000_0000_8000_001C, 1'b0, 2,     5,     10,        1'b0};
    vecs[2] = '{64'h0000_0000_8000_0040, 1'b1, 0,     0,     1,         1'b1};
    vecs[3] = '{64'h0000_0000_8000_0100, 1'b0, 0,     NEVER, T_OUT + 3, 1'b1};
    vecs[4] = '{64'h0000_0000_0000_1234, 1'b0, 1,     0,     4,         1'b0};
    vecs[5] = '{64'h0000_0000_8000_0200, 1'b0, NEVER, 0,     T_OUT + 2, 1'b1};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFF7, 1'b0, 5,     0,     8,         1'b0};
    vecs[7] = '{64'h0000_0000_8000_0300, 1'b0, 0,     5,     8,         1'b0};

    rst          = 1'b0;
    i_rw_valid_i = 1'b0;
    i_rw_req_i   = 1'b0;
    i_rw_addr_i  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(i_rw_ready_o), 128'h0);
    chk("rst_err",   128'(i_rw_err_o),   128'h0);
    chk("rst_req",   128'(mem_req_o),    128'h0);
    chk("rst_addr",  128'(mem_addr_o),   128'h0);
    chk("rst_data",  i_data_read_o,      128'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Reset while BEAT0 is waiting for an ack
    begin
      int rd0;
      dly0 = NEVER;
      dly1 = 0;
      rd0  = ready_cnt;
      i_rw_valid_i = 1'b1;
      i_rw_req_i   = 1'b0;
      i_rw_addr_i  = 64'h0000_0000_8000_0500;
      @(posedge clk); #1;
      i_rw_valid_i = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_req_before", 128'(mem_req_o), 128'h1);
      chk("mid_rst_addr_before", 128'(mem_addr_o), 128'h8000_0500);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_req",   128'(mem_req_o),    128'h0);
      chk("mid_rst_addr",  128'(mem_addr_o),   128'h0);
      chk("mid_rst_ready", 128'(i_rw_ready_o), 128'h0);
      chk("mid_rst_err",   128'(i_rw_err_o),   128'h0);
      chk("mid_rst_data",  i_data_read_o,      128'h0);
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_rst_no_pulse", 128'(ready_cnt - rd0), 128'h0);
      run_vec("after_rst", '{64'h0000_0000_8000_0600, 1'b0, 1, 1, 5, 1'b0});
    end

    // Valid held high across RESP with the address changing mid-transaction
    begin
      int rd0;
      logic [63:0] a_addr;
      logic [63:0] b_addr;
      a_addr = 64'h0000_0000_8000_0400;
      b_addr = 64'h0000_0000_8000_0508;
      dly0 = 0;
      dly1 = 0;
      rd0  = ready_cnt;
      i_rw_valid_i = 1'b1;
      i_rw_req_i   = 1'b0;
      i_rw_addr_i  = a_addr;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk); #1;
        chk($sformatf("held_ready_c%0d", c), 128'(i_rw_ready_o),
            128'((c == 3) || (c == 7)));
        if (c == 2) i_rw_addr_i = b_addr;
        if (c == 3) chk("held_data_a", i_data_read_o, line_of(a_addr & ~64'hF));
        if (c == 5) begin
          chk("held_b_beat0_addr", 128'(mem_addr_o), 128'(b_addr & ~64'hF));
          i_rw_valid_i = 1'b0;
        end
        if (c == 7) chk("held_data_b", i_data_read_o, line_of(b_addr & ~64'hF));
      end
      chk("held_pulses", 128'(ready_cnt - rd0), 128'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
